// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the shared ALU and alu_arbiter.
// The arbiter takes the slave view; the requesters and the ALU take the master view.
interface alu_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [31:0] req0_a_i;
    logic [31:0] req0_b_i;
    logic [3:0]  req0_op_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [31:0] req1_a_i;
    logic [31:0] req1_b_i;
    logic [3:0]  req1_op_i;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_res_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        input  alu_res_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output alu_a_o, alu_b_o, alu_op_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        output alu_res_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_a_o, alu_b_o, alu_op_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational RV32I ALU between two requesters and registers the result
// into a single response channel tagged with the requester id.
module alu_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
);
    logic [1:0]  req_valid;
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [3:0]  req_op [2];
    logic [1:0]  ready;

    logic        grant_any;
    logic        grant_id;
    logic        can_accept;
    logic        fire;
    logic        fire_id;
    logic        err_op;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q,    rsp_id_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        last_q,      last_d;
    logic [3:0]  starve_q,    starve_d;

    assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
    assign req_a[0]  = bus.req0_a_i;
    assign req_a[1]  = bus.req1_a_i;
    assign req_b[0]  = bus.req0_b_i;
    assign req_b[1]  = bus.req1_b_i;
    assign req_op[0] = bus.req0_op_i;
    assign req_op[1] = bus.req1_op_i;

    assign can_accept = !rsp_valid_q || bus.rsp_ready_i;
    assign grant_any  = |req_valid;

    always_comb begin
        grant_id = 1'b0;
        if (PRIORITY_MODE != 0) begin
            // Port 1 only wins when port 0 is idle or port 1 has waited out its starvation budget.
            if (req_valid[1] && (!req_valid[0] || starve_q == 4'(STARVE_LIMIT)))
                grant_id = 1'b1;
        end else begin
            if (req_valid[0] && req_valid[1])
                grant_id = !last_q;
            else if (req_valid[1])
                grant_id = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = grant_any && (grant_id == 1'(gi)) && req_valid[gi]
                               && can_accept && !rst_i;
        end
    endgenerate

    assign bus.req0_ready_o = ready[0];
    assign bus.req1_ready_o = ready[1];

    assign bus.alu_a_o  = grant_any ? req_a[grant_id]  : 32'd0;
    assign bus.alu_b_o  = grant_any ? req_b[grant_id]  : 32'd0;
    assign bus.alu_op_o = grant_any ? req_op[grant_id] : 4'd0;

    assign fire    = |ready;
    assign fire_id = ready[1];
    assign err_op  = (bus.alu_op_o >= 4'b1010) && (bus.alu_op_o <= 4'b1110);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        last_d      = last_q;
        starve_d    = starve_q;

        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = fire_id;
            rsp_data_d  = err_op ? 32'd0 : bus.alu_res_i;
            rsp_err_d   = err_op;
            last_d      = fire_id;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        // Starvation counter tracks consecutive port-0 wins while port 1 is waiting.
        if (!req_valid[1] || ready[1])
            starve_d = 4'd0;
        else if (ready[0] && starve_q < 4'(STARVE_LIMIT))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            last_q      <= 1'b1;
            starve_q    <= 4'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_id_o    = rsp_id_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance, each fed by a
// behavioural RV32I ALU, checked with immediate assertions against hand-computed values.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_arbiter_if b0 ();
    alu_arbiter_if b1 ();

    alu_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(4)) u_rr (
        .clk_i (clk), .rst_i (rst), .bus (b0.slave)
    );
    alu_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(4)) u_pr (
        .clk_i (clk), .rst_i (rst), .bus (b1.slave)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd15:   return b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign b0.alu_res_i = alu_model(b0.alu_a_o, b0.alu_b_o, b0.alu_op_o);
    assign b1.alu_res_i = alu_model(b1.alu_a_o, b1.alu_b_o, b1.alu_op_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("assertion %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        b0.req0_valid_i = v; b0.req0_a_i = a; b0.req0_b_i = b; b0.req0_op_i = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        b0.req1_valid_i = v; b0.req1_a_i = a; b0.req1_b_i = b; b0.req1_op_i = op;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id,
                           input logic [31:0] d, input logic e);
        chk({tag, "_valid"}, 32'(b0.rsp_valid_o), 32'(v));
        chk({tag, "_id"},    32'(b0.rsp_id_o),    32'(id));
        chk({tag, "_data"},  b0.rsp_data_o,       d);
        chk({tag, "_err"},   32'(b0.rsp_err_o),   32'(e));
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        b0.rsp_ready_i = 1'b1;
        b1.req0_valid_i = 1'b0; b1.req0_a_i = 32'd1; b1.req0_b_i = 32'd1; b1.req0_op_i = 4'd0;
        b1.req1_valid_i = 1'b0; b1.req1_a_i = 32'd2; b1.req1_b_i = 32'd2; b1.req1_op_i = 4'd0;
        b1.rsp_ready_i = 1'b1;
        repeat (2) tick();
        chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);

        // Single request on port 0: 5 + 7.
        rst = 1'b0;
        drive0(1'b1, 32'd5, 32'd7, 4'd0);
        #1;
        chk("add_ready0", 32'(b0.req0_ready_o), 32'd1);
        chk("add_ready1", 32'(b0.req1_ready_o), 32'd0);
        chk("add_alu_a",  b0.alu_a_o, 32'd5);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        chk_rsp("add", 1'b1, 1'b0, 32'd12, 1'b0);
        #1;
        chk("idle_alu_a",  b0.alu_a_o, 32'd0);
        chk("idle_alu_op", 32'(b0.alu_op_o), 32'd0);
        tick();
        chk_rsp("drain", 1'b0, 1'b0, 32'd12, 1'b0);

        // Round robin: port 0 fired last, so port 1 goes first.
        drive0(1'b1, 32'd9, 32'd3, 4'd1);
        drive1(1'b1, 32'd1, 32'd4, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 32'(b0.req0_ready_o), 32'(i % 2 == 1));
            chk("rr_ready1", 32'(b0.req1_ready_o), 32'(i % 2 == 0));
            tick();
            chk_rsp("rr", 1'b1, 1'(i % 2 == 0), (i % 2 == 0) ? 32'd16 : 32'd6, 1'b0);
        end

        // Backpressure: response held, both readies low, ALU still shows the granted port.
        b0.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", 32'(b0.req0_ready_o), 32'd0);
            chk("bp_ready1", 32'(b0.req1_ready_o), 32'd0);
            chk("bp_alu_a",  b0.alu_a_o, 32'd1);
            tick();
            chk_rsp("bp", 1'b1, 1'b0, 32'd6, 1'b0);
        end
        b0.rsp_ready_i = 1'b1;
        #1;
        chk("rel_ready1", 32'(b0.req1_ready_o), 32'd1);
        tick();
        chk_rsp("rel", 1'b1, 1'b1, 32'd16, 1'b0);
        #1;
        chk("rel_ready0", 32'(b0.req0_ready_o), 32'd1);
        tick();
        chk_rsp("rel2", 1'b1, 1'b0, 32'd6, 1'b0);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);

        // Unused opcode gives an error with zero data; op 1111 passes B through.
        drive1(1'b1, 32'd0, 32'd0, 4'b1011);
        tick();
        chk_rsp("err", 1'b1, 1'b1, 32'd0, 1'b1);
        drive1(1'b1, 32'd3, 32'h12345000, 4'b1111);
        tick();
        chk_rsp("lui", 1'b1, 1'b1, 32'h12345000, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        chk_rsp("drain2", 1'b0, 1'b1, 32'h12345000, 1'b0);

        // Reset while a response is pending; afterwards port 0 wins first.
        b0.rsp_ready_i = 1'b0;
        drive0(1'b1, 32'd2, 32'd3, 4'd0);
        tick();
        chk_rsp("pend", 1'b1, 1'b0, 32'd5, 1'b0);
        drive1(1'b1, 32'd6, 32'd2, 4'd1);
        rst = 1'b1;
        #1;
        chk("rst_ready0", 32'(b0.req0_ready_o), 32'd0);
        chk("rst_ready1", 32'(b0.req1_ready_o), 32'd0);
        tick();
        chk_rsp("rst_pend", 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        b0.rsp_ready_i = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(b0.req0_ready_o), 32'd1);
        chk("post_rst_ready1", 32'(b0.req1_ready_o), 32'd0);
        tick();
        chk_rsp("post_rst", 1'b1, 1'b0, 32'd5, 1'b0);
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Fixed priority with a starvation limit of 4: grants 0,0,0,0,1 repeating.
        b1.req0_valid_i = 1'b1;
        b1.req1_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("pr_ready0", 32'(b1.req0_ready_o), 32'(i % 5 != 4));
            chk("pr_ready1", 32'(b1.req1_ready_o), 32'(i % 5 == 4));
            tick();
            chk("pr_id",   32'(b1.rsp_id_o), 32'(i % 5 == 4));
            chk("pr_data", b1.rsp_data_o, (i % 5 == 4) ? 32'd4 : 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
